// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator: sync pulses, active-area flag, pixel
// coordinates and line/frame strobes. Optional VGA_TIMING_FRAME_COUNT_EN builds frame_count.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE        = 1920,
  parameter int unsigned H_FP            = 88,
  parameter int unsigned H_SYNC          = 44,
  parameter int unsigned H_BP            = 148,
  parameter int unsigned V_ACTIVE        = 1080,
  parameter int unsigned V_FP            = 4,
  parameter int unsigned V_SYNC          = 5,
  parameter int unsigned V_BP            = 36,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned X_W             = 12,
  parameter int unsigned Y_W             = 11,
  parameter int unsigned FRAME_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clock_en,
  output logic               h_sync,
  output logic               v_sync,
  output logic               in_display_area,
  output logic [X_W-1:0]     x_pos,
  output logic [Y_W-1:0]     y_pos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS      = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_VIS      = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] VS_FIRST   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic           SYNC_IDLE  = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [X_W-1:0] xc;
  logic [Y_W-1:0] yc;
  logic           x_wrap;
  logic           y_wrap;
  logic           h_act;
  logic           v_act;
  logic           vis;

  always_comb begin
    x_wrap = (xc == H_LAST);
    y_wrap = (yc == V_LAST);
    h_act  = (xc >= HS_FIRST) && (xc <= HS_LAST);
    v_act  = (yc >= VS_FIRST) && (yc <= VS_LAST);
    vis    = (xc < H_VIS) && (yc < V_VIS);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xc <= '0;
      yc <= '0;
    end else if (clock_en) begin
      if (x_wrap) begin
        xc <= '0;
        yc <= y_wrap ? '0 : yc + Y_W'(1);
      end else begin
        xc <= xc + X_W'(1);
      end
    end
  end

  // Outputs sample the pre-increment counters so they all share one edge of latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_pos           <= '0;
      y_pos           <= '0;
      h_sync          <= SYNC_IDLE;
      v_sync          <= SYNC_IDLE;
      in_display_area <= 1'b0;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
    end else if (clock_en) begin
      x_pos           <= xc;
      y_pos           <= yc;
      h_sync          <= h_act ^ SYNC_IDLE;
      v_sync          <= v_act ^ SYNC_IDLE;
      in_display_area <= vis;
      line_start      <= (xc == '0);
      frame_start     <= (xc == '0) && (yc == '0);
    end else begin
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (clock_en && x_wrap && y_wrap) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator on a small 14x8 raster:
// vector table for reset/first line, then geometry, enable, reset and frame-count sequences.
module tb_vga_timing_generator;

  localparam int unsigned HT = 14;
  localparam int unsigned VT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clock_en = 1'b1;
  logic       h_sync, v_sync, in_display_area, line_start, frame_start;
  logic [3:0] x_pos;
  logic [2:0] y_pos;
  logic [1:0] frame_count;

  int n_vec = 0;
  int n_bad = 0;

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_LOW(1'b1), .X_W(4), .Y_W(3), .FRAME_W(2)
  ) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .h_sync(h_sync), .v_sync(v_sync), .in_display_area(in_display_area),
    .x_pos(x_pos), .y_pos(y_pos), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [2:0] y;
    logic [3:0] x;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [11:0] pk(logic hs, logic vs, logic de, logic ls,
                                     logic fs, logic [2:0] y, logic [3:0] x);
    return {hs, vs, de, ls, fs, y, x};
  endfunction

  // Expected outputs after the n-th enabled edge (0-based) since reset release.
  function automatic logic [11:0] model(int unsigned n);
    int unsigned x, y;
    x = n % HT;
    y = (n / HT) % VT;
    return pk(!(x >= 10 && x <= 12), !(y >= 5 && y <= 6), (x < 8) && (y < 4),
              x == 0, (x == 0) && (y == 0), 3'(y), 4'(x));
  endfunction

  function automatic logic [11:0] actual();
    return pk(h_sync, v_sync, in_display_area, line_start, frame_start, y_pos, x_pos);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    clock_en = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int last_ls, last_fs, ls_per, fs_per, hs_low, vs_low, ls_cnt, n;
    logic [11:0] exp_b, last_b;
    logic [1:0]  fc3, fc4, fc2;

    // rst en hs vs de ls fs y x
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd4};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd6};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd7};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd10};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd11};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd12};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd13};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd1};

`ifdef VGA_TIMING_FRAME_COUNT_EN
    fc2 = 2'd2; fc3 = 2'd3; fc4 = 2'd0;
`else
    fc2 = 2'd0; fc3 = 2'd0; fc4 = 2'd0;
`endif

    for (int i = 0; i < 19; i++) begin
      reset    = vecs[i].rst;
      clock_en = vecs[i].en;
      step();
      check($sformatf("vec%0d", i), 32'(actual()),
            32'(pk(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].ls, vecs[i].fs,
                   vecs[i].y, vecs[i].x)));
    end

    // Two full frames at full rate: every output, plus sync widths and strobe periods.
    restart();
    last_ls = -1; last_fs = -1; ls_per = 0; fs_per = 0; hs_low = 0; vs_low = 0;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      step();
      check("geom", 32'(actual()), 32'(model(k)));
      if (k < HT && !h_sync) hs_low++;
      if (k < HT * VT && !v_sync) vs_low++;
      if (line_start) begin
        if (last_ls >= 0) ls_per = k - last_ls;
        last_ls = k;
      end
      if (frame_start) begin
        if (last_fs >= 0) fs_per = k - last_fs;
        last_fs = k;
      end
      if (k == HT * VT - 1) check("pre_wrap", 32'({y_pos, x_pos}), 32'({3'd7, 4'd13}));
      if (k == HT * VT)     check("wrap", 32'({y_pos, x_pos}), 32'd0);
    end
    check("hsync_width", hs_low, 3);
    check("vsync_width", vs_low, 28);
    check("line_period", ls_per, 14);
    check("frame_period", fs_per, 112);
    check("fc_2frames", 32'(frame_count), 32'(fc2));

    // Enable toggling 1,0,1,0: outputs hold, strobes last one clock.
    restart();
    n = 0; ls_cnt = 0; last_ls = -1; ls_per = 0; last_b = '0;
    for (int c = 0; c < 4 * HT; c++) begin
      clock_en = (c % 2 == 0);
      step();
      if (clock_en) begin
        exp_b = model(n);
        n++;
      end else begin
        exp_b = last_b & 12'hE7F;
      end
      last_b = exp_b;
      check("enable", 32'(actual()), 32'(exp_b));
      if (line_start) begin
        ls_cnt++;
        if (last_ls >= 0) ls_per = c - last_ls;
        last_ls = c;
      end
    end
    check("en_ls_count", ls_cnt, 2);
    check("en_line_period", ls_per, 28);

    // Asynchronous reset mid-frame, then restart from the origin.
    restart();
    for (int k = 0; k < 3 * HT + 6; k++) step();
    check("pre_reset", 32'(actual()), 32'(pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd5)));
    reset = 1'b1;
    #1;
    check("async_reset", 32'(actual()), 32'(pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0)));
    check("async_reset_fc", 32'(frame_count), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_reset", 32'(actual()), 32'(pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0)));
    step();
    check("post_reset2", 32'(actual()), 32'(model(1)));

    // Frame counter mid-frame after 3 and 4 completed frames (2-bit wrap).
    restart();
    for (int k = 1; k <= 4 * HT * VT + 5; k++) begin
      step();
      if (k == 3 * HT * VT + 5) check("fc_3frames", 32'(frame_count), 32'(fc3));
      if (k == 4 * HT * VT + 5) check("fc_4frames", 32'(frame_count), 32'(fc4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
